// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial sequence detector: a KMP prefix automaton whose
// transition table is built at elaboration, plus a saturating match counter.
module moore_seq_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     COUNT_W     = 8,
    localparam int                    SW          = $clog2(PATTERN_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               x_in,
    input  logic               x_valid,
    input  logic               clear,
    output logic               y_out,
    output logic [SW-1:0]      state_out,
    output logic [COUNT_W-1:0] match_count
);

    typedef logic [SW-1:0] state_t;

    localparam state_t S_FULL = state_t'(PATTERN_LEN);

    if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
        $error("moore_seq_detector: PATTERN_LEN must be in 2..16");
    end

    // Longest pattern prefix that is a suffix of prefix(k) followed by b.
    // PATTERN[PATTERN_LEN-1] is the first bit of the stream.
    function automatic int kmp_next(input int k, input bit b);
        int result;
        int base;
        bit ok;
        bit s_bit;
        result = 0;
        for (int j = 1; j <= PATTERN_LEN; j++) begin
            if (j <= k + 1) begin
                ok   = 1'b1;
                base = k + 1 - j;
                for (int i = 0; i < j; i++) begin
                    if (base + i >= k) begin
                        s_bit = b;
                    end else begin
                        s_bit = PATTERN[PATTERN_LEN-1-(base+i)];
                    end
                    if (s_bit != PATTERN[PATTERN_LEN-1-i]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    result = j;
                end
            end
        end
        return result;
    endfunction

    logic [PATTERN_LEN:0][SW-1:0] nxt0_tbl;
    logic [PATTERN_LEN:0][SW-1:0] nxt1_tbl;

    // Evaluating from the full-match state k=L yields the same result as
    // stepping from its longest proper border, which is the overlap rule.
    for (genvar k = 0; k <= PATTERN_LEN; k++) begin : g_tbl
        localparam int SRC = (k == PATTERN_LEN && !OVERLAP) ? 0 : k;
        localparam int N0  = kmp_next(SRC, 1'b0);
        localparam int N1  = kmp_next(SRC, 1'b1);
        assign nxt0_tbl[k] = state_t'(N0);
        assign nxt1_tbl[k] = state_t'(N1);
    end

    state_t             state_q, state_d;
    state_t             nxt;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        nxt     = x_in ? nxt1_tbl[state_q] : nxt0_tbl[state_q];
        if (clear) begin
            state_d = '0;
            count_d = '0;
        end else if (x_valid) begin
            state_d = nxt;
            if (nxt == S_FULL && count_q != '1) begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    assign y_out       = (state_q == S_FULL);
    assign state_out   = state_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: four parameterisations share one
// input stream; each task resets, drives bits and checks against hand values.
`timescale 1ns/1ps
module tb_moore_seq_detector;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic x_in = 1'b0;
    logic x_valid = 1'b0;
    logic clear = 1'b0;

    logic       ov_y, no_y, sat_y, p2_y;
    logic [2:0] ov_st, no_st, sat_st;
    logic [1:0] p2_st;
    logic [7:0] ov_cnt, no_cnt, p2_cnt;
    logic [1:0] sat_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    moore_seq_detector u_ov (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
        .y_out(ov_y), .state_out(ov_st), .match_count(ov_cnt)
    );

    moore_seq_detector #(.OVERLAP(1'b0)) u_no (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
        .y_out(no_y), .state_out(no_st), .match_count(no_cnt)
    );

    moore_seq_detector #(.COUNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
        .y_out(sat_y), .state_out(sat_st), .match_count(sat_cnt)
    );

    moore_seq_detector #(.PATTERN_LEN(2), .PATTERN(2'b11)) u_p2 (
        .clock(clock), .reset(reset), .x_in(x_in), .x_valid(x_valid), .clear(clear),
        .y_out(p2_y), .state_out(p2_st), .match_count(p2_cnt)
    );

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; x_valid = 1'b0; clear = 1'b0; x_in = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drive one bit on the falling edge, return 1 ns after the next rising edge.
    task automatic send_bit(input logic b, input logic v, input logic c);
        @(negedge clock);
        x_in = b; x_valid = v; clear = c;
        @(posedge clock);
        #1;
        x_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({ov_y, ov_st, ov_cnt} !== 12'h000) begin
            failures++;
            $display("FAIL reset_ov: y=%b st=%0d cnt=%0d required 0/0/0", ov_y, ov_st, ov_cnt);
        end
        checks++;
        if ({p2_y, p2_st, p2_cnt} !== 11'h000) begin
            failures++;
            $display("FAIL reset_p2: y=%b st=%0d cnt=%0d required 0/0/0", p2_y, p2_st, p2_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        int exp_st [7] = '{1, 2, 3, 4, 2, 3, 4};
        bits = 7'b1011011;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_bit(bits[6-i], 1'b1, 1'b0);
            checks++;
            if (ov_st !== 3'(exp_st[i]) || ov_y !== (exp_st[i] == 4)) begin
                failures++;
                $display("FAIL overlap_bit%0d: st=%0d y=%b required st=%0d y=%b",
                         i + 1, ov_st, ov_y, exp_st[i], exp_st[i] == 4);
            end
        end
        checks++;
        if (ov_cnt !== 8'd2) begin
            failures++;
            $display("FAIL overlap_count: got %0d required 2", ov_cnt);
        end
    endtask

    task automatic test_non_overlap();
        logic [6:0] bits;
        int exp_st [7] = '{1, 2, 3, 4, 0, 1, 1};
        bits = 7'b1011011;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_bit(bits[6-i], 1'b1, 1'b0);
            checks++;
            if (no_st !== 3'(exp_st[i]) || no_y !== (exp_st[i] == 4)) begin
                failures++;
                $display("FAIL nonoverlap_bit%0d: st=%0d y=%b required st=%0d y=%b",
                         i + 1, no_st, no_y, exp_st[i], exp_st[i] == 4);
            end
        end
        checks++;
        if (no_cnt !== 8'd1) begin
            failures++;
            $display("FAIL nonoverlap_count: got %0d required 1", no_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        do_reset();
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
            checks++;
            if (ov_st !== 3'd2 || ov_y !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold%0d: st=%0d y=%b required st=2 y=0", i, ov_st, ov_y);
            end
        end
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        checks++;
        if (ov_st !== 3'd4 || ov_y !== 1'b1 || ov_cnt !== 8'd1) begin
            failures++;
            $display("FAIL gap_match: st=%0d y=%b cnt=%0d required 4/1/1", ov_st, ov_y, ov_cnt);
        end
        // Idle cycle while matched: output and count must hold.
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (ov_st !== 3'd4 || ov_y !== 1'b1 || ov_cnt !== 8'd1) begin
            failures++;
            $display("FAIL gap_match_hold: st=%0d y=%b cnt=%0d required 4/1/1", ov_st, ov_y, ov_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] bits;
        logic [3:0] pat;
        bits = 6'b101101;
        pat = 4'b1011;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_bit(bits[5-i], 1'b1, 1'b0);
        end
        checks++;
        if (ov_st !== 3'd3 || ov_cnt !== 8'd1) begin
            failures++;
            $display("FAIL areset_setup: st=%0d cnt=%0d required 3/1", ov_st, ov_cnt);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ov_st !== 3'd0 || ov_y !== 1'b0 || ov_cnt !== 8'd0) begin
            failures++;
            $display("FAIL areset_immediate: st=%0d y=%b cnt=%0d required 0/0/0", ov_st, ov_y, ov_cnt);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_bit(pat[3-i], 1'b1, 1'b0);
        end
        checks++;
        if (ov_st !== 3'd4 || ov_y !== 1'b1 || ov_cnt !== 8'd1) begin
            failures++;
            $display("FAIL areset_restart: st=%0d y=%b cnt=%0d required 4/1/1", ov_st, ov_y, ov_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [12:0] bits;
        int k;
        logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        bits = 13'b1011011011011;
        k = 0;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send_bit(bits[12-i], 1'b1, 1'b0);
            if (i == 3 || i == 6 || i == 9 || i == 12) begin
                checks++;
                if (sat_cnt !== exp_cnt[k] || sat_y !== 1'b1) begin
                    failures++;
                    $display("FAIL sat_match%0d: cnt=%0d y=%b required cnt=%0d y=1",
                             k + 1, sat_cnt, sat_y, exp_cnt[k]);
                end
                k++;
            end
        end
        checks++;
        if (ov_cnt !== 8'd4) begin
            failures++;
            $display("FAIL wide_count: got %0d required 4", ov_cnt);
        end
    endtask

    task automatic test_clear();
        logic [5:0] bits;
        bits = 6'b101101;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_bit(bits[5-i], 1'b1, 1'b0);
        end
        send_bit(1'b1, 1'b1, 1'b1);
        checks++;
        if (ov_st !== 3'd0 || ov_y !== 1'b0 || ov_cnt !== 8'd0) begin
            failures++;
            $display("FAIL clear_priority: st=%0d y=%b cnt=%0d required 0/0/0", ov_st, ov_y, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int exp_st [3] = '{1, 2, 2};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b1, 1'b1, 1'b0);
            checks++;
            if (p2_st !== 2'(exp_st[i]) || p2_y !== (i > 0)) begin
                failures++;
                $display("FAIL p2_bit%0d: st=%0d y=%b required st=%0d y=%b",
                         i + 1, p2_st, p2_y, exp_st[i], i > 0);
            end
        end
        checks++;
        if (p2_cnt !== 8'd2) begin
            failures++;
            $display("FAIL p2_count: got %0d required 2", p2_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_valid_gaps();
        test_async_reset();
        test_saturation();
        test_clear();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
